aes_round_sequencer: RTL and testbench

- Control FSM that sequences the AES-128 round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey state array) through round 0 (AddRoundKey only), rounds 1..NR-1 (full) and round NR (no MixColumns).
- Owns the round counter and Rcon generation for key expansion.
- Accepts blocks via a valid/ready handshake, presents completion via valid/ready.
- Watches for a stalled datapath with a timeout.

---
 rtl/aes_round_sequencer_if.sv | 31 +++
 rtl/aes_round_sequencer.sv | 160 ++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_sequencer_if.sv
// Control/handshake bundle between the AES round sequencer (master) and the
// datapath plus block source/sink that surround it (slave).
interface aes_round_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic        load_state;
  logic        rnd_req;
  logic        rnd_ack;
  logic [3:0]  round_idx;
  logic [7:0]  rcon;
  logic        skip_sub_shift;
  logic        skip_mix;
  logic        out_valid;
  logic        out_ready;
  logic        abort;
  logic        err;
  logic        clr_err;
  logic [15:0] blocks_done;

  modport master (
    input  in_valid, rnd_ack, out_ready, abort, clr_err,
    output in_ready, load_state, rnd_req, round_idx, rcon,
           skip_sub_shift, skip_mix, out_valid, err, blocks_done
  );

  modport slave (
    output in_valid, rnd_ack, out_ready, abort, clr_err,
    input  in_ready, load_state, rnd_req, round_idx, rcon,
           skip_sub_shift, skip_mix, out_valid, err, blocks_done
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// AES-128 round control FSM: accepts a block, steps the datapath through rounds
// 0..NR with Rcon generation, presents completion and flags a stalled datapath.
module aes_round_sequencer #(
  parameter int NR      = 10,
  parameter int TIMEOUT = 15
) (
  input logic                   CLOCK,
  input logic                   RESET,
  aes_round_sequencer_if.master bus
);
  localparam int            CW         = $clog2(TIMEOUT + 1);
  localparam logic [3:0]    LAST_ROUND = 4'(NR);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TMO_ONE    = CW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t        state_r;
  logic [CW-1:0] tmo_cnt_r;
  logic          in_ready_r;
  logic          load_state_r;
  logic          rnd_req_r;
  logic          out_valid_r;
  logic          err_r;
  logic          skip_sub_shift_r;
  logic          skip_mix_r;
  logic [3:0]    round_idx_r;
  logic [7:0]    rcon_r;
  logic [15:0]   blocks_done_r;
  logic          abortable_s;

  // GF(2^8) multiply-by-x used to step the round constant
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  assign abortable_s = (state_r == LOAD) || (state_r == ROUND) || (state_r == DONE);

  // Sequencer state, timeout counter and every registered control output
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_r          <= IDLE;
      tmo_cnt_r        <= '0;
      in_ready_r       <= 1'b1;
      load_state_r     <= 1'b0;
      rnd_req_r        <= 1'b0;
      out_valid_r      <= 1'b0;
      err_r            <= 1'b0;
      skip_sub_shift_r <= 1'b0;
      skip_mix_r       <= 1'b0;
      round_idx_r      <= 4'd0;
      rcon_r           <= 8'h00;
      blocks_done_r    <= 16'h0000;
    end else begin
      load_state_r <= 1'b0;
      if (bus.abort && abortable_s) begin
        // abort beats a same-cycle output handshake, so blocks_done is untouched
        state_r          <= IDLE;
        tmo_cnt_r        <= '0;
        in_ready_r       <= 1'b1;
        rnd_req_r        <= 1'b0;
        out_valid_r      <= 1'b0;
        skip_sub_shift_r <= 1'b0;
        skip_mix_r       <= 1'b0;
        round_idx_r      <= 4'd0;
        rcon_r           <= 8'h00;
      end else begin
        case (state_r)
          IDLE: begin
            if (bus.in_valid && in_ready_r) begin
              state_r      <= LOAD;
              in_ready_r   <= 1'b0;
              load_state_r <= 1'b1;
            end
          end
          LOAD: begin
            state_r          <= ROUND;
            tmo_cnt_r        <= '0;
            rnd_req_r        <= 1'b1;
            round_idx_r      <= 4'd0;
            skip_sub_shift_r <= 1'b1;
            skip_mix_r       <= 1'b1;
            rcon_r           <= 8'h00;
          end
          ROUND: begin
            if (bus.rnd_ack) begin
              tmo_cnt_r <= '0;
              if (round_idx_r == LAST_ROUND) begin
                state_r     <= DONE;
                rnd_req_r   <= 1'b0;
                out_valid_r <= 1'b1;
              end else begin
                round_idx_r      <= round_idx_r + 4'd1;
                skip_sub_shift_r <= 1'b0;
                skip_mix_r       <= ((round_idx_r + 4'd1) == LAST_ROUND);
                rcon_r           <= (round_idx_r == 4'd0) ? 8'h01 : xtime(rcon_r);
              end
            end else if (tmo_cnt_r == TMO_LAST) begin
              // this edge is the TIMEOUT-th without an ack
              state_r          <= ERR;
              tmo_cnt_r        <= '0;
              err_r            <= 1'b1;
              rnd_req_r        <= 1'b0;
              skip_sub_shift_r <= 1'b0;
              skip_mix_r       <= 1'b0;
              round_idx_r      <= 4'd0;
              rcon_r           <= 8'h00;
            end else begin
              tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
            end
          end
          DONE: begin
            if (bus.out_ready) begin
              state_r          <= IDLE;
              out_valid_r      <= 1'b0;
              in_ready_r       <= 1'b1;
              blocks_done_r    <= blocks_done_r + 16'h0001;
              skip_sub_shift_r <= 1'b0;
              skip_mix_r       <= 1'b0;
              round_idx_r      <= 4'd0;
              rcon_r           <= 8'h00;
            end
          end
          ERR: begin
            if (bus.clr_err) begin
              state_r    <= IDLE;
              err_r      <= 1'b0;
              in_ready_r <= 1'b1;
            end
          end
          default: begin
            state_r     <= IDLE;
            tmo_cnt_r   <= '0;
            in_ready_r  <= 1'b1;
            rnd_req_r   <= 1'b0;
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready       = in_ready_r;
  assign bus.load_state     = load_state_r;
  assign bus.rnd_req        = rnd_req_r;
  assign bus.out_valid      = out_valid_r;
  assign bus.err            = err_r;
  assign bus.skip_sub_shift = skip_sub_shift_r;
  assign bus.skip_mix       = skip_mix_r;
  assign bus.round_idx      = round_idx_r;
  assign bus.rcon           = rcon_r;
  assign bus.blocks_done    = blocks_done_r;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed-plus-random bench for aes_round_sequencer; inputs are driven and
// outputs sampled on the falling clock edge.
module tb_aes_round_sequencer;
  localparam int NR      = 10;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   exp_done = 0;
  logic [7:0] rcon_tab [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  aes_round_sequencer_if sif();

  aes_round_sequencer #(.NR(NR), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  // Hard stop if the sequence ever stalls
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Round constant as x^(r-1) in GF(2^8) modulo the AES polynomial
  function automatic int ref_rcon(input int r);
    int v;
    if (r == 0) return 0;
    v = 1;
    for (int i = 1; i < r; i++) begin
      v = v * 2;
      if (v > 255) v = v ^ 32'h11B;
    end
    return v;
  endfunction

  task automatic check_reset_values();
    check("rst_in_ready", 32'(sif.in_ready), 1);
    check("rst_load_state", 32'(sif.load_state), 0);
    check("rst_rnd_req", 32'(sif.rnd_req), 0);
    check("rst_out_valid", 32'(sif.out_valid), 0);
    check("rst_err", 32'(sif.err), 0);
    check("rst_round_idx", 32'(sif.round_idx), 0);
    check("rst_rcon", 32'(sif.rcon), 0);
    check("rst_skip_sub", 32'(sif.skip_sub_shift), 0);
    check("rst_skip_mix", 32'(sif.skip_mix), 0);
    check("rst_blocks_done", 32'(sif.blocks_done), 0);
  endtask

  // From IDLE: handshake, check the LOAD cycle, end observing round 0
  task automatic start_block();
    check("start_in_ready", 32'(sif.in_ready), 1);
    sif.in_valid = 1'b1;
    step();
    sif.in_valid = 1'b0;
    check("load_pulse", 32'(sif.load_state), 1);
    check("load_in_ready", 32'(sif.in_ready), 0);
    check("load_rnd_req", 32'(sif.rnd_req), 0);
    step();
    check("load_pulse_end", 32'(sif.load_state), 0);
  endtask

  // Acks rounds first..last; slow_round waits slow_delay cycles, others random
  task automatic run_rounds(input int first, input int last, input int slow_round,
                            input int slow_delay);
    for (int r = first; r <= last; r++) begin
      int d;
      d = (r == slow_round) ? slow_delay : int'($urandom_range(0, 3));
      for (int w = 0; w <= d; w++) begin
        check("round_idx", 32'(sif.round_idx), r);
        check("rcon", 32'(sif.rcon), ref_rcon(r));
        check("skip_sub_shift", 32'(sif.skip_sub_shift), (r == 0) ? 1 : 0);
        check("skip_mix", 32'(sif.skip_mix), (r == 0 || r == NR) ? 1 : 0);
        check("rnd_req_high", 32'(sif.rnd_req), 1);
        check("out_valid_low", 32'(sif.out_valid), 0);
        check("err_low", 32'(sif.err), 0);
        sif.rnd_ack = (w == d);
        step();
      end
      sif.rnd_ack = 1'b0;
    end
  endtask

  // Observing DONE: complete the output handshake
  task automatic finish_block();
    check("done_out_valid", 32'(sif.out_valid), 1);
    check("done_rnd_req", 32'(sif.rnd_req), 0);
    check("done_in_ready", 32'(sif.in_ready), 0);
    sif.out_ready = 1'b1;
    step();
    sif.out_ready = 1'b0;
    exp_done = (exp_done + 1) & 32'hFFFF;
    check("blocks_done", 32'(sif.blocks_done), exp_done);
    check("post_out_valid", 32'(sif.out_valid), 0);
    check("post_in_ready", 32'(sif.in_ready), 1);
  endtask

  // Ack driven purely from rnd_req; records what each acked round presented
  task automatic measure_latency(input bit delayed);
    logic [3:0] idxq [$];
    logic [7:0] rconq [$];
    logic       mixq [$];
    int  cnt, nloads;
    bit  waited;
    sif.in_valid = 1'b1;
    step();
    sif.in_valid = 1'b0;
    cnt = 1;
    nloads = 0;
    waited = 1'b0;
    while (!sif.out_valid && cnt < 80) begin
      if (sif.load_state) nloads++;
      if (sif.rnd_req && (!delayed || waited)) begin
        sif.rnd_ack = 1'b1;
        waited = 1'b0;
        idxq.push_back(sif.round_idx);
        rconq.push_back(sif.rcon);
        mixq.push_back(sif.skip_mix);
      end else begin
        sif.rnd_ack = 1'b0;
        waited = sif.rnd_req;
      end
      step();
      cnt++;
    end
    sif.rnd_ack = 1'b0;
    check("lat_out_valid_cycle", cnt, 1 + (NR + 1) * (delayed ? 2 : 1) + 1);
    check("lat_load_pulses", nloads, 1);
    check("lat_num_acks", idxq.size(), NR + 1);
    for (int i = 0; i < idxq.size() && i <= NR; i++) begin
      check("seq_round_idx", 32'(idxq[i]), i);
      check("seq_rcon", 32'(rconq[i]), 32'(rcon_tab[i]));
      check("seq_skip_mix", 32'(mixq[i]), (i == 0 || i == NR) ? 1 : 0);
    end
    finish_block();
  endtask

  initial begin
    sif.in_valid  = 1'b0;
    sif.rnd_ack   = 1'b0;
    sif.out_ready = 1'b0;
    sif.abort     = 1'b0;
    sif.clr_err   = 1'b0;
    #12;
    check_reset_values();
    step();
    rst = 1'b0;
    step();
    check_reset_values();

    // stray ack in IDLE is ignored
    sif.rnd_ack = 1'b1;
    step();
    sif.rnd_ack = 1'b0;
    check("idle_ack_rnd_req", 32'(sif.rnd_req), 0);
    check("idle_ack_in_ready", 32'(sif.in_ready), 1);

    // DONE held 5 cycles with in_valid asserted, then blocks_done 0 -> 1
    start_block();
    run_rounds(0, NR, -1, 0);
    sif.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", 32'(sif.out_valid), 1);
      check("hold_in_ready", 32'(sif.in_ready), 0);
      check("hold_load_state", 32'(sif.load_state), 0);
      step();
    end
    sif.in_valid = 1'b0;
    finish_block();

    // latency with same-cycle ack, then with ack one cycle after req
    measure_latency(1'b0);
    measure_latency(1'b1);

    // random ack gaps and random consumer back-pressure
    for (int b = 0; b < 3; b++) begin
      int hold;
      start_block();
      run_rounds(0, NR, -1, 0);
      hold = int'($urandom_range(0, 3));
      for (int i = 0; i < hold; i++) begin
        check("rand_hold_out_valid", 32'(sif.out_valid), 1);
        step();
      end
      finish_block();
    end

    // stall at round 3: err on the TIMEOUT-th edge after the last ack
    start_block();
    run_rounds(0, 2, -1, 0);
    for (int w = 1; w <= TIMEOUT; w++) begin
      step();
      if (w < TIMEOUT) begin
        check("tmo_err_low", 32'(sif.err), 0);
        check("tmo_req_high", 32'(sif.rnd_req), 1);
      end
    end
    check("tmo_err_set", 32'(sif.err), 1);
    check("tmo_req_low", 32'(sif.rnd_req), 0);
    check("tmo_out_valid", 32'(sif.out_valid), 0);
    check("tmo_in_ready", 32'(sif.in_ready), 0);
    sif.abort = 1'b1;
    step();
    sif.abort = 1'b0;
    check("err_abort_ignored", 32'(sif.err), 1);
    check("err_abort_in_ready", 32'(sif.in_ready), 0);
    sif.clr_err = 1'b1;
    step();
    sif.clr_err = 1'b0;
    check("clr_err_err", 32'(sif.err), 0);
    check("clr_err_in_ready", 32'(sif.in_ready), 1);
    check("clr_err_blocks", 32'(sif.blocks_done), exp_done);

    // ack on the last allowed edge wins over the timeout
    start_block();
    run_rounds(0, NR, 4, TIMEOUT - 1);
    finish_block();

    // abort at round 7, then an immediate normal block
    start_block();
    run_rounds(0, 6, -1, 0);
    check("pre_abort_idx", 32'(sif.round_idx), 7);
    sif.abort = 1'b1;
    step();
    sif.abort = 1'b0;
    check("abort_rnd_req", 32'(sif.rnd_req), 0);
    check("abort_round_idx", 32'(sif.round_idx), 0);
    check("abort_rcon", 32'(sif.rcon), 0);
    check("abort_in_ready", 32'(sif.in_ready), 1);
    check("abort_out_valid", 32'(sif.out_valid), 0);
    check("abort_blocks", 32'(sif.blocks_done), exp_done);
    start_block();
    run_rounds(0, NR, -1, 0);
    finish_block();

    // abort together with the output handshake: no count
    start_block();
    run_rounds(0, NR, -1, 0);
    sif.abort     = 1'b1;
    sif.out_ready = 1'b1;
    step();
    sif.abort     = 1'b0;
    sif.out_ready = 1'b0;
    check("abort_hs_blocks", 32'(sif.blocks_done), exp_done);
    check("abort_hs_out_valid", 32'(sif.out_valid), 0);
    check("abort_hs_in_ready", 32'(sif.in_ready), 1);

    // blocks_done wrap from a forced 0xFFFF
    force dut.blocks_done_r = 16'hFFFF;
    #1;
    release dut.blocks_done_r;
    exp_done = 32'hFFFF;
    step();
    start_block();
    run_rounds(0, NR, -1, 0);
    finish_block();
    check("wrap_zero", 32'(sif.blocks_done), 0);

    // asynchronous reset in the middle of round 5
    start_block();
    run_rounds(0, 4, -1, 0);
    check("pre_rst_idx", 32'(sif.round_idx), 5);
    check("pre_rst_req", 32'(sif.rnd_req), 1);
    #2;
    rst = 1'b1;
    #1;
    exp_done = 0;
    check_reset_values();
    step();
    rst = 1'b0;
    step();
    check("post_rst_in_ready", 32'(sif.in_ready), 1);
    check("post_rst_req", 32'(sif.rnd_req), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
